// File: rtl/hsv_core_pkg.sv
// Shared types for the hsv_core flush path.
//   word_t        : 32-bit machine word (PCs, flush targets)
//   flush_state_t : flush coordinator phase
package hsv_core_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FLUSH_IDLE,
    FLUSH_RAISE,
    FLUSH_DRAIN
  } flush_state_t;

endpackage

// File: rtl/hsv_core_flush_coordinator_if.sv
// Flush handshake bundle between the control path, the coordinator and the pipeline units.
//   req_valid/req_target         : flush request from the control path
//   flush_req/flush_target       : broadcast to the units
//   flush_ack[NUM_UNITS]         : per-unit ack levels
//   flush_active/flush_done      : coordinator status
//   timeout/timeout_units        : watchdog status (zero when the watchdog is not built)
// master = coordinator side, slave = environment side.
interface hsv_core_flush_coordinator_if #(
  parameter int unsigned NUM_UNITS = 9
);
  import hsv_core_pkg::*;

  logic                 req_valid;
  word_t                req_target;
  logic                 flush_req;
  word_t                flush_target;
  logic [NUM_UNITS-1:0] flush_ack;
  logic                 flush_active;
  logic                 flush_done;
  logic                 timeout;
  logic [NUM_UNITS-1:0] timeout_units;

  modport master (
    input  req_valid, req_target, flush_ack,
    output flush_req, flush_target, flush_active, flush_done, timeout, timeout_units
  );

  modport slave (
    output req_valid, req_target, flush_ack,
    input  flush_req, flush_target, flush_active, flush_done, timeout, timeout_units
  );

endinterface

// File: rtl/hsv_core_flush_watchdog.sv
// Per-phase watchdog for the flush coordinator.
//   i_clk_core, i_rst_core_n : clock, synchronous active-low reset
//   i_in_raise, i_in_drain   : coordinator is in RAISE / DRAIN
//   i_phase_exit             : coordinator leaves its current phase on this edge
//   i_flush_ack              : raw per-unit ack levels
//   o_timeout                : sticky flag, set once a phase has lasted TIMEOUT_CYCLES cycles
//   o_timeout_units          : participating units whose ack was wrong when the flag was set
module hsv_core_flush_watchdog #(
  parameter int unsigned          NUM_UNITS      = 9,
  parameter logic [NUM_UNITS-1:0] ACK_MASK       = '1,
  parameter int unsigned          TIMEOUT_CYCLES = 1024
) (
  input  logic                 i_clk_core,
  input  logic                 i_rst_core_n,
  input  logic                 i_in_raise,
  input  logic                 i_in_drain,
  input  logic                 i_phase_exit,
  input  logic [NUM_UNITS-1:0] i_flush_ack,
  output logic                 o_timeout,
  output logic [NUM_UNITS-1:0] o_timeout_units
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0]      r_cnt;
  logic                 r_timeout;
  logic [NUM_UNITS-1:0] r_units;
  logic                 w_busy;
  logic                 w_hit;

  assign w_busy = i_in_raise | i_in_drain;
  // r_cnt holds the number of completed cycles in this phase; the edge that completes
  // cycle TIMEOUT_CYCLES raises the flag.
  assign w_hit  = w_busy && !i_phase_exit && (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk_core) begin
    if (!i_rst_core_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_units   <= '0;
    end else begin
      if (!w_busy || i_phase_exit) begin
        r_cnt <= '0;
      end else if (r_cnt != CntW'(TIMEOUT_CYCLES)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_hit && !r_timeout) begin
        r_timeout <= 1'b1;
        r_units   <= ACK_MASK & (i_in_raise ? ~i_flush_ack : i_flush_ack);
      end
    end
  end

  assign o_timeout       = r_timeout;
  assign o_timeout_units = r_units;

endmodule

// File: rtl/hsv_core_flush_coordinator.sv
// Flush handshake coordinator for the hsv_core pipeline.
// Latches a flush request, broadcasts flush_req/flush_target to NUM_UNITS units, waits for
// every participating unit to raise its ack (RAISE), then for all acks to fall (DRAIN).
// Requests during RAISE retarget the current flush; requests during DRAIN queue one more flush.
//   i_clk_core, i_rst_core_n : clock, synchronous active-low reset
//   io_flush (master)        : request in, broadcast out, acks in, status out
// Optional watchdog built when HSV_FLUSH_TIMEOUT_EN is defined; otherwise timeout outputs are 0.
module hsv_core_flush_coordinator
  import hsv_core_pkg::*;
#(
  parameter int unsigned          NUM_UNITS      = 9,
  parameter logic [NUM_UNITS-1:0] ACK_MASK       = '1,
  parameter int unsigned          TIMEOUT_CYCLES = 1024
) (
  input  logic                          i_clk_core,
  input  logic                          i_rst_core_n,
  hsv_core_flush_coordinator_if.master  io_flush
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  flush_state_t         r_state;
  word_t                r_target;
  word_t                r_pend_target;
  logic                 r_pending;
  logic                 r_flush_req;
  logic [NUM_UNITS-1:0] w_eff;
  logic                 w_all_hi;
  logic                 w_any_hi;
  logic                 w_leave;

  // Masked-out units count as always-high for the raise and always-low for the drain.
  assign w_eff    = io_flush.flush_ack & ACK_MASK;
  assign w_all_hi = &(w_eff | ~ACK_MASK);
  assign w_any_hi = |w_eff;

  always_comb begin
    w_leave = 1'b0;
    unique case (r_state)
      FLUSH_IDLE:  w_leave = io_flush.req_valid | r_pending;
      FLUSH_RAISE: w_leave = w_all_hi;
      FLUSH_DRAIN: w_leave = ~w_any_hi;
      default:     w_leave = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk_core) begin
    if (!i_rst_core_n) begin
      r_state       <= FLUSH_IDLE;
      r_target      <= '0;
      r_pend_target <= '0;
      r_pending     <= 1'b0;
      r_flush_req   <= 1'b0;
    end else begin
      unique case (r_state)
        FLUSH_IDLE: begin
          if (w_leave) begin
            r_state     <= FLUSH_RAISE;
            r_flush_req <= 1'b1;
            r_pending   <= 1'b0;
            // A fresh request is newer than anything left pending.
            r_target    <= io_flush.req_valid ? io_flush.req_target : r_pend_target;
          end
        end
        FLUSH_RAISE: begin
          if (io_flush.req_valid) r_target <= io_flush.req_target;
          if (w_leave) begin
            r_state     <= FLUSH_DRAIN;
            r_flush_req <= 1'b0;
          end
        end
        FLUSH_DRAIN: begin
          if (io_flush.req_valid) begin
            r_pending     <= 1'b1;
            r_pend_target <= io_flush.req_target;
          end
          if (w_leave) begin
            if (r_pending) begin
              r_state     <= FLUSH_RAISE;
              r_flush_req <= 1'b1;
              r_target    <= r_pend_target;
              // The old pending entry is consumed; a request on this edge stays queued.
              r_pending   <= io_flush.req_valid;
            end else begin
              r_state <= FLUSH_IDLE;
            end
          end
        end
        default: begin
          r_state     <= FLUSH_IDLE;
          r_flush_req <= 1'b0;
        end
      endcase
    end
  end

  assign io_flush.flush_req    = r_flush_req;
  assign io_flush.flush_target = r_target;
  assign io_flush.flush_active = (r_state != FLUSH_IDLE);
  // Done marks the completing DRAIN cycle itself, so it is decoded from the live acks.
  assign io_flush.flush_done   = i_rst_core_n && (r_state == FLUSH_DRAIN) && !w_any_hi &&
                                 !r_pending;

`ifdef HSV_FLUSH_TIMEOUT_EN
  hsv_core_flush_watchdog #(
    .NUM_UNITS      (NUM_UNITS),
    .ACK_MASK       (ACK_MASK),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk_core      (i_clk_core),
    .i_rst_core_n    (i_rst_core_n),
    .i_in_raise      (r_state == FLUSH_RAISE),
    .i_in_drain      (r_state == FLUSH_DRAIN),
    .i_phase_exit    (w_leave),
    .i_flush_ack     (io_flush.flush_ack),
    .o_timeout       (io_flush.timeout),
    .o_timeout_units (io_flush.timeout_units)
  );
`else
  assign io_flush.timeout       = 1'b0;
  assign io_flush.timeout_units = '0;
`endif

endmodule

// File: tb/tb_hsv_core_flush_coordinator.sv
// Bench for hsv_core_flush_coordinator: two instances (full mask, and mask 9'h1FE) share
// stimulus; every cycle both are compared against a behavioural model, plus a table for the
// basic handshake and directed sequences for merge, pending, mask, reset and watchdog cases.
module tb_hsv_core_flush_coordinator;
  import hsv_core_pkg::*;

  localparam int unsigned N  = 9;
  localparam int unsigned TO = 16;
  localparam logic [N-1:0] MASK_A = 9'h1FF;
  localparam logic [N-1:0] MASK_M = 9'h1FE;
  localparam int PH_IDLE = 0, PH_RAISE = 1, PH_DRAIN = 2;

  typedef struct packed {
    logic         req;
    logic [31:0]  tgt;
    logic         act;
    logic         done;
    logic         to;
    logic [N-1:0] units;
  } obs_t;

  typedef struct {
    bit           rv;
    logic [31:0]  rt;
    logic [N-1:0] ack;
    logic         e_req;
    logic [31:0]  e_tgt;
    logic         e_act;
    logic         e_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hsv_core_flush_coordinator_if #(.NUM_UNITS(N)) bus_a ();
  hsv_core_flush_coordinator_if #(.NUM_UNITS(N)) bus_m ();

  hsv_core_flush_coordinator #(.NUM_UNITS(N), .ACK_MASK(MASK_A), .TIMEOUT_CYCLES(TO)) dut_a (
    .i_clk_core   (clk),
    .i_rst_core_n (rst_n),
    .io_flush     (bus_a)
  );
  hsv_core_flush_coordinator #(.NUM_UNITS(N), .ACK_MASK(MASK_M), .TIMEOUT_CYCLES(TO)) dut_m (
    .i_clk_core   (clk),
    .i_rst_core_n (rst_n),
    .io_flush     (bus_m)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state, index 0 = dut_a, 1 = dut_m.
  int           ph    [2];
  logic [31:0]  tgt   [2];
  logic [31:0]  ptgt  [2];
  bit           pend  [2];
  int           dwell [2];
  bit           to_f  [2];
  logic [N-1:0] to_u  [2];
  logic [N-1:0] msk   [2];

  obs_t sa, sm;
  int   done_a = 0, done_m = 0, rises_a = 0;
  logic prev_req_a = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic model_expect(input int k, input logic [N-1:0] ack, input bit rn,
                              output obs_t e);
    e.req   = (ph[k] == PH_RAISE);
    e.tgt   = tgt[k];
    e.act   = (ph[k] != PH_IDLE);
    e.done  = rn && (ph[k] == PH_DRAIN) && ((ack & msk[k]) == '0) && !pend[k];
    e.to    = to_f[k];
    e.units = to_u[k];
  endtask

  // One more cycle spent waiting inside a phase.
  task automatic tick(input int k, input logic [N-1:0] ack);
`ifdef HSV_FLUSH_TIMEOUT_EN
    dwell[k]++;
    if (dwell[k] == TO && !to_f[k]) begin
      to_f[k] = 1'b1;
      to_u[k] = msk[k] & ((ph[k] == PH_RAISE) ? ~ack : ack);
    end
`else
    dwell[k] = 0;
`endif
  endtask

  task automatic model_step(input int k, input bit rv, input logic [31:0] rt,
                            input logic [N-1:0] ack, input bit rn);
    logic [N-1:0] seen;
    bit all_in, none;
    seen   = ack & msk[k];
    all_in = (seen == msk[k]);
    none   = (seen == '0);
    if (!rn) begin
      ph[k] = PH_IDLE; tgt[k] = '0; ptgt[k] = '0; pend[k] = 1'b0;
      dwell[k] = 0; to_f[k] = 1'b0; to_u[k] = '0;
      return;
    end
    case (ph[k])
      PH_IDLE: begin
        if (rv || pend[k]) begin
          tgt[k] = rv ? rt : ptgt[k];
          pend[k] = 1'b0; ph[k] = PH_RAISE; dwell[k] = 0;
        end
      end
      PH_RAISE: begin
        if (rv) tgt[k] = rt;
        if (all_in) begin ph[k] = PH_DRAIN; dwell[k] = 0; end
        else tick(k, ack);
      end
      default: begin
        if (none) begin
          if (pend[k]) begin tgt[k] = ptgt[k]; ph[k] = PH_RAISE; pend[k] = 1'b0; end
          else ph[k] = PH_IDLE;
          dwell[k] = 0;
        end else tick(k, ack);
        if (rv) begin pend[k] = 1'b1; ptgt[k] = rt; end
      end
    endcase
  endtask

  task automatic cmp_obs(input string p, input obs_t got, input obs_t exp);
    chk($sformatf("%s.flush_req", p),     got.req,   exp.req);
    chk($sformatf("%s.flush_target", p),  got.tgt,   exp.tgt);
    chk($sformatf("%s.flush_active", p),  got.act,   exp.act);
    chk($sformatf("%s.flush_done", p),    got.done,  exp.done);
    chk($sformatf("%s.timeout", p),       got.to,    exp.to);
    chk($sformatf("%s.timeout_units", p), got.units, exp.units);
  endtask

  // Drive one cycle (inputs just after posedge), sample/compare at negedge, advance the model.
  task automatic cyc(input bit rv, input logic [31:0] rt, input logic [N-1:0] ack, input bit rn);
    obs_t ea, em;
    bus_a.req_valid = rv; bus_a.req_target = rt; bus_a.flush_ack = ack;
    bus_m.req_valid = rv; bus_m.req_target = rt; bus_m.flush_ack = ack;
    rst_n = rn;
    @(negedge clk);
    sa = {bus_a.flush_req, bus_a.flush_target, bus_a.flush_active, bus_a.flush_done,
          bus_a.timeout, bus_a.timeout_units};
    sm = {bus_m.flush_req, bus_m.flush_target, bus_m.flush_active, bus_m.flush_done,
          bus_m.timeout, bus_m.timeout_units};
    model_expect(0, ack, rn, ea);
    model_expect(1, ack, rn, em);
    cmp_obs("a", sa, ea);
    cmp_obs("m", sm, em);
    if (sa.done) done_a++;
    if (sm.done) done_m++;
    if (sa.req && !prev_req_a) rises_a++;
    prev_req_a = sa.req;
    model_step(0, rv, rt, ack, rn);
    model_step(1, rv, rt, ack, rn);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];
  initial begin
    int d0, r0, first;
    bit saw_to;
    logic [N-1:0] ack, ack_r;
    bit rv, rn;

    msk[0] = MASK_A;
    msk[1] = MASK_M;
    // Basic handshake, request at row 0.
    vecs[0] = '{1, 32'h8000_0100, 9'h000, 0, 32'h0,         0, 0};
    vecs[1] = '{0, 32'h0,         9'h000, 1, 32'h8000_0100, 1, 0};
    vecs[2] = '{0, 32'h0,         9'h000, 1, 32'h8000_0100, 1, 0};
    vecs[3] = '{0, 32'h0,         9'h1FF, 1, 32'h8000_0100, 1, 0};
    vecs[4] = '{0, 32'h0,         9'h1FF, 0, 32'h8000_0100, 1, 0};
    vecs[5] = '{0, 32'h0,         9'h1FF, 0, 32'h8000_0100, 1, 0};
    vecs[6] = '{0, 32'h0,         9'h000, 0, 32'h8000_0100, 1, 1};
    vecs[7] = '{0, 32'h0,         9'h000, 0, 32'h8000_0100, 0, 0};

    bus_a.req_valid = 1'b0; bus_a.req_target = '0; bus_a.flush_ack = '0;
    bus_m.req_valid = 1'b0; bus_m.req_target = '0; bus_m.flush_ack = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_step(0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0);

    // Reset state
    cyc(0, 0, 0, 1);
    chk("rst.flush_req", sa.req, 0);
    chk("rst.flush_target", sa.tgt, 0);
    chk("rst.flush_active", sa.act, 0);
    chk("rst.timeout", sa.to, 0);

    // Basic table
    for (int i = 0; i < 8; i++) begin
      cyc(vecs[i].rv, vecs[i].rt, vecs[i].ack, 1);
      chk($sformatf("basic[%0d].flush_req", i), sa.req, vecs[i].e_req);
      chk($sformatf("basic[%0d].flush_target", i), sa.tgt, vecs[i].e_tgt);
      chk($sformatf("basic[%0d].flush_active", i), sa.act, vecs[i].e_act);
      chk($sformatf("basic[%0d].flush_done", i), sa.done, vecs[i].e_done);
    end

    // Staggered acks
    cyc(1, 32'h0000_1000, 0, 1);
    ack = '0;
    for (int i = 0; i < N; i++) begin
      ack[i] = 1'b1;
      cyc(0, 0, ack, 1);
      chk($sformatf("stag.req_held[%0d]", i), sa.req, 1);
    end
    cyc(0, 0, 9'h1FF, 1);
    chk("stag.req_dropped", sa.req, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 9'h010, 1);
      chk("stag.no_done_unit4", sa.done, 0);
    end
    cyc(0, 0, 0, 1);
    chk("stag.done", sa.done, 1);
    cyc(0, 0, 0, 1);
    chk("stag.idle", sa.act, 0);

    // Merge in RAISE
    d0 = done_a; r0 = rises_a;
    cyc(1, 32'h100, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 32'h200, 0, 1);
    cyc(0, 0, 0, 1);
    chk("merge.target", sa.tgt, 32'h200);
    cyc(0, 0, 9'h1FF, 1);
    cyc(0, 0, 9'h1FF, 1);
    repeat (3) cyc(0, 0, 0, 1);
    chk("merge.done_count", done_a - d0, 1);
    chk("merge.flush_count", rises_a - r0, 1);

    // Pending in DRAIN
    d0 = done_a;
    cyc(1, 32'h100, 0, 1);
    cyc(0, 0, 9'h1FF, 1);
    cyc(1, 32'h300, 9'h1FF, 1);
    cyc(0, 0, 9'h1FF, 1);
    cyc(0, 0, 0, 1);
    chk("pend.no_done", sa.done, 0);
    cyc(0, 0, 0, 1);
    chk("pend.req_again", sa.req, 1);
    chk("pend.target", sa.tgt, 32'h300);
    cyc(0, 0, 9'h1FF, 1);
    cyc(0, 0, 0, 1);
    chk("pend.done_second", sa.done, 1);
    cyc(0, 0, 0, 1);
    chk("pend.done_count", done_a - d0, 1);

    // Mask: unit 0 stuck low on dut_m completes; dut_a stays stuck in RAISE
    d0 = done_m;
    cyc(1, 32'h500, 0, 1);
    repeat (3) cyc(0, 0, 9'h1FE, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("mask.done_count", done_m - d0, 1);
    chk("mask.m_idle", sm.act, 0);
    chk("mask.a_stuck", sa.act, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("mask.a_reset_idle", sa.act, 0);
    chk("mask.a_reset_req", sa.req, 0);

    // Reset mid-drain: no done
    cyc(1, 32'h600, 0, 1);
    cyc(0, 0, 9'h1FF, 1);
    cyc(0, 0, 9'h1FF, 1);
    cyc(0, 0, 0, 0);
    chk("rstmid.no_done", sa.done, 0);
    cyc(0, 0, 0, 1);
    chk("rstmid.idle", sa.act, 0);
    chk("rstmid.target", sa.tgt, 0);

    // Watchdog: unit 2 never acks
    first = -1; saw_to = 1'b0;
    cyc(1, 32'h400, 9'h1FB, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 9'h1FB, 1);
      if (sa.to === 1'b1 && first < 0) first = i;
      if (sa.to === 1'b1) saw_to = 1'b1;
    end
`ifdef HSV_FLUSH_TIMEOUT_EN
    chk("to.first_cycle", first, 16);
    chk("to.units_a", sa.units, 9'h004);
    chk("to.units_m", sm.units, 9'h004);
`else
    chk("to.never", saw_to, 0);
    chk("to.units_zero", sa.units, 0);
`endif
    chk("to.still_raise", sa.req, 1);
    cyc(0, 0, 9'h1FB, 0);
    cyc(0, 0, 0, 1);
    chk("to.cleared", sa.to, 0);
    chk("to.units_cleared", sa.units, 0);
    chk("to.idle", sa.act, 0);

    // Randomized traffic against the model
    ack_r = '0;
    for (int i = 0; i < 1500; i++) begin
      rv = ($urandom_range(0, 5) == 0);
      rn = ($urandom_range(0, 299) != 0);
      case (ph[0])
        PH_RAISE: ack_r = ack_r | (N'($urandom) & N'($urandom));
        PH_DRAIN: ack_r = ack_r & N'($urandom);
        default:  ack_r = N'($urandom) & N'($urandom);
      endcase
      cyc(rv, $urandom, ack_r, rn);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
